// File: rtl/itag_ctl.sv
// Upstream sequencer for the instruction-cache tag array: invalidate walk, lookup, miss fill and tag write.
// Outputs decode from state, walk counter and capture registers; idle cycles replay the last driven values.
module itag_ctl #(
    parameter int IDX_W = 10,
    parameter int TAG_W = 18,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             lkup_vld,
    input  logic [IDX_W-1:0] lkup_idx,
    input  logic [TAG_W-1:0] lkup_tag,
    input  logic             flush_req,
    input  logic             fill_ack,
    input  logic             ic_hit,
    output logic [IDX_W-1:0] icu_tag_addr,
    output logic [TAG_W-1:0] icu_tag_in,
    output logic             icu_tag_vld,
    output logic             icu_tag_we,
    output logic             fill_req,
    output logic             lkup_done,
    output logic             lkup_hit,
    output logic             busy,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic [2:0] INIT  = 3'd0;
    localparam logic [2:0] IDLE  = 3'd1;
    localparam logic [2:0] LOOK  = 3'd2;
    localparam logic [2:0] MISS  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] FLUSH = 3'd5;

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    logic [2:0]       state;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] cap_idx;
    logic [TAG_W-1:0] cap_tag;
    logic             flush_pend;
    logic [CNT_W-1:0] miss_q;
    logic [IDX_W-1:0] last_addr;
    logic [TAG_W-1:0] last_in;
    logic             last_vld;
    logic             start_lkup;

    assign start_lkup = (state == IDLE) && !flush_pend && lkup_vld && enable;
    assign miss_cnt   = miss_q;

    always_comb begin
        icu_tag_addr = last_addr;
        icu_tag_in   = last_in;
        icu_tag_vld  = last_vld;
        icu_tag_we   = 1'b0;
        fill_req     = 1'b0;
        lkup_done    = 1'b0;
        lkup_hit     = 1'b0;
        busy         = 1'b1;
        case (state)
            INIT, FLUSH: begin
                icu_tag_addr = cnt;
                icu_tag_in   = '0;
                icu_tag_vld  = 1'b0;
                icu_tag_we   = 1'b1;
            end
            IDLE: begin
                busy = 1'b0;
                // address goes straight to the array so ic_hit is valid in LOOK
                if (start_lkup) begin
                    icu_tag_addr = lkup_idx;
                    icu_tag_in   = lkup_tag;
                end
            end
            LOOK: begin
                icu_tag_addr = cap_idx;
                icu_tag_in   = cap_tag;
                lkup_done    = 1'b1;
                lkup_hit     = ic_hit;
            end
            MISS: begin
                icu_tag_addr = cap_idx;
                icu_tag_in   = cap_tag;
                fill_req     = 1'b1;
            end
            WRITE: begin
                icu_tag_addr = cap_idx;
                icu_tag_in   = cap_tag;
                icu_tag_vld  = 1'b1;
                icu_tag_we   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            cnt        <= '0;
            cap_idx    <= '0;
            cap_tag    <= '0;
            flush_pend <= 1'b0;
            miss_q     <= '0;
            last_addr  <= '0;
            last_in    <= '0;
            last_vld   <= 1'b0;
        end else begin
            last_addr <= icu_tag_addr;
            last_in   <= icu_tag_in;
            last_vld  <= icu_tag_vld;

            // a pulse arriving as the flush starts is absorbed by that flush
            if (state == IDLE && flush_pend)
                flush_pend <= 1'b0;
            else if (flush_req && state != INIT && state != FLUSH)
                flush_pend <= 1'b1;

            case (state)
                INIT, FLUSH: begin
                    if (cnt == LAST_IDX) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                IDLE: begin
                    if (flush_pend) begin
                        state <= FLUSH;
                    end else if (start_lkup) begin
                        cap_idx <= lkup_idx;
                        cap_tag <= lkup_tag;
                        state   <= LOOK;
                    end
                end
                LOOK: begin
                    if (ic_hit) begin
                        state <= IDLE;
                    end else begin
                        if (miss_q != '1)
                            miss_q <= miss_q + CNT_W'(1);
                        state <= MISS;
                    end
                end
                MISS: begin
                    if (fill_ack)
                        state <= WRITE;
                end
                WRITE: state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_itag_ctl.sv
// Directed bench for itag_ctl: table of per-cycle vectors plus hand-written walk, flush, reset and saturation sequences.
module tb_itag_ctl;

    localparam int IDX_W = 10;
    localparam int TAG_W = 18;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset, enable, lkup_vld, flush_req, fill_ack, ic_hit;
    logic [IDX_W-1:0] lkup_idx, icu_tag_addr;
    logic [TAG_W-1:0] lkup_tag, icu_tag_in;
    logic             icu_tag_vld, icu_tag_we, fill_req, lkup_done, lkup_hit, busy;
    logic [CNT_W-1:0] miss_cnt;

    logic       s_reset, s_enable, s_lkup_vld, s_flush_req, s_fill_ack, s_ic_hit;
    logic [1:0] s_lkup_idx, s_addr;
    logic [3:0] s_lkup_tag, s_in;
    logic       s_vld, s_we, s_fill_req, s_done, s_hit, s_busy;
    logic [1:0] s_miss;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    itag_ctl #(.IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .lkup_vld(lkup_vld),
        .lkup_idx(lkup_idx), .lkup_tag(lkup_tag), .flush_req(flush_req),
        .fill_ack(fill_ack), .ic_hit(ic_hit), .icu_tag_addr(icu_tag_addr),
        .icu_tag_in(icu_tag_in), .icu_tag_vld(icu_tag_vld), .icu_tag_we(icu_tag_we),
        .fill_req(fill_req), .lkup_done(lkup_done), .lkup_hit(lkup_hit),
        .busy(busy), .miss_cnt(miss_cnt)
    );

    // narrow instance so the miss counter can reach saturation quickly
    itag_ctl #(.IDX_W(2), .TAG_W(4), .CNT_W(2)) sdut (
        .clk(clk), .reset(s_reset), .enable(s_enable), .lkup_vld(s_lkup_vld),
        .lkup_idx(s_lkup_idx), .lkup_tag(s_lkup_tag), .flush_req(s_flush_req),
        .fill_ack(s_fill_ack), .ic_hit(s_ic_hit), .icu_tag_addr(s_addr),
        .icu_tag_in(s_in), .icu_tag_vld(s_vld), .icu_tag_we(s_we),
        .fill_req(s_fill_req), .lkup_done(s_done), .lkup_hit(s_hit),
        .busy(s_busy), .miss_cnt(s_miss)
    );

    typedef struct {
        logic             lv, en, fl, ack, hit;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [63:0]      exp;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [63:0] ex(input int a, input int d, input int v, input int w,
                                       input int fr, input int dn, input int ht, input int bz,
                                       input int m);
        return {14'd0, a[9:0], d[17:0], v[0], w[0], fr[0], dn[0], ht[0], bz[0], m[15:0]};
    endfunction

    function automatic vec_t mk(input int lv, input int en, input int idx, input int tag,
                                input int fl, input int ack, input int hit, input logic [63:0] e);
        vec_t r;
        r.lv  = lv[0];
        r.en  = en[0];
        r.idx = idx[9:0];
        r.tag = tag[17:0];
        r.fl  = fl[0];
        r.ack = ack[0];
        r.hit = hit[0];
        r.exp = e;
        return r;
    endfunction

    function automatic logic [63:0] outs();
        return {14'd0, icu_tag_addr, icu_tag_in, icu_tag_vld, icu_tag_we, fill_req,
                lkup_done, lkup_hit, busy, miss_cnt};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        lkup_vld = 1'b0; flush_req = 1'b0; fill_ack = 1'b0; ic_hit = 1'b0; enable = 1'b1;
        lkup_idx = '0; lkup_tag = '0;
    endtask

    initial begin
        reset = 1'b1; quiet();
        s_reset = 1'b1; s_enable = 1'b1; s_lkup_vld = 1'b0; s_flush_req = 1'b0;
        s_fill_ack = 1'b0; s_ic_hit = 1'b0; s_lkup_idx = '0; s_lkup_tag = '0;

        //                lv en idx     tag      fl ack hit   addr    in       v we fr dn ht bz m
        tbl[0]  = mk(0, 1, 0,      0,       0, 0, 0, ex('h3FF, 0,       0, 0, 0, 0, 0, 0, 0));
        tbl[1]  = mk(1, 1, 'h5,    'h2A,    0, 0, 0, ex('h5,   'h2A,    0, 0, 0, 0, 0, 0, 0));
        tbl[2]  = mk(0, 1, 0,      0,       0, 0, 1, ex('h5,   'h2A,    0, 0, 0, 1, 1, 1, 0));
        tbl[3]  = mk(0, 1, 0,      0,       0, 0, 0, ex('h5,   'h2A,    0, 0, 0, 0, 0, 0, 0));
        tbl[4]  = mk(1, 1, 'h3FF,  'h3FFFF, 0, 0, 0, ex('h3FF, 'h3FFFF, 0, 0, 0, 0, 0, 0, 0));
        tbl[5]  = mk(1, 1, 'h3FF,  'h3FFFF, 0, 0, 0, ex('h3FF, 'h3FFFF, 0, 0, 0, 1, 0, 1, 0));
        tbl[6]  = mk(0, 1, 0,      0,       0, 0, 0, ex('h3FF, 'h3FFFF, 0, 0, 1, 0, 0, 1, 1));
        tbl[7]  = mk(0, 0, 0,      0,       0, 0, 0, ex('h3FF, 'h3FFFF, 0, 0, 1, 0, 0, 1, 1));
        tbl[8]  = mk(0, 1, 0,      0,       0, 0, 0, ex('h3FF, 'h3FFFF, 0, 0, 1, 0, 0, 1, 1));
        tbl[9]  = mk(0, 1, 0,      0,       0, 0, 0, ex('h3FF, 'h3FFFF, 0, 0, 1, 0, 0, 1, 1));
        tbl[10] = mk(0, 1, 0,      0,       0, 1, 0, ex('h3FF, 'h3FFFF, 0, 0, 1, 0, 0, 1, 1));
        tbl[11] = mk(0, 1, 0,      0,       0, 0, 0, ex('h3FF, 'h3FFFF, 1, 1, 0, 0, 0, 1, 1));
        tbl[12] = mk(1, 0, 'h7,    'h1,     0, 0, 0, ex('h3FF, 'h3FFFF, 1, 0, 0, 0, 0, 0, 1));
        tbl[13] = mk(0, 1, 0,      0,       0, 1, 0, ex('h3FF, 'h3FFFF, 1, 0, 0, 0, 0, 0, 1));
        tbl[14] = mk(1, 1, 'h10,   'h123,   0, 0, 0, ex('h10,  'h123,   1, 0, 0, 0, 0, 0, 1));
        tbl[15] = mk(0, 1, 0,      0,       0, 0, 1, ex('h10,  'h123,   1, 0, 0, 1, 1, 1, 1));
        tbl[16] = mk(0, 1, 0,      0,       0, 0, 0, ex('h10,  'h123,   1, 0, 0, 0, 0, 0, 1));

        tick(); tick();
        reset = 1'b0;

        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            chk($sformatf("init_walk%0d", i), outs(), ex(i, 0, 0, 1, 0, 0, 0, 1, 0));
            tick();
        end
        @(negedge clk);
        chk("init_end", outs(), ex('h3FF, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();

        for (int i = 0; i < 17; i++) begin
            lkup_vld = tbl[i].lv; enable = tbl[i].en; lkup_idx = tbl[i].idx; lkup_tag = tbl[i].tag;
            flush_req = tbl[i].fl; fill_ack = tbl[i].ack; ic_hit = tbl[i].hit;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
            tick();
        end
        quiet();

        // flush raised during a miss: fill and write finish first, held lookup waits for the walk
        lkup_vld = 1'b1; lkup_idx = 10'h20; lkup_tag = 18'h55;
        tick();
        lkup_vld = 1'b0; ic_hit = 1'b0;
        tick();
        flush_req = 1'b1;
        @(negedge clk);
        chk("flush_miss_enter", outs(), ex('h20, 'h55, 1, 0, 1, 0, 0, 1, 2));
        tick();
        flush_req = 1'b0;
        tick();
        fill_ack = 1'b1;
        @(negedge clk);
        chk("flush_miss_held", outs(), ex('h20, 'h55, 1, 0, 1, 0, 0, 1, 2));
        tick();
        fill_ack = 1'b0; lkup_vld = 1'b1; lkup_idx = 10'h30; lkup_tag = 18'h66;
        @(negedge clk);
        chk("flush_write", outs(), ex('h20, 'h55, 1, 1, 0, 0, 0, 1, 2));
        tick();
        @(negedge clk);
        chk("flush_priority", outs(), ex('h20, 'h55, 1, 0, 0, 0, 0, 0, 2));
        tick();
        for (int i = 0; i < 1024; i++) begin
            flush_req = (i == 500);
            @(negedge clk);
            chk($sformatf("flush_walk%0d", i), outs(), ex(i, 0, 0, 1, 0, 0, 0, 1, 2));
            tick();
        end
        flush_req = 1'b0;
        @(negedge clk);
        chk("flush_served", outs(), ex('h30, 'h66, 0, 0, 0, 0, 0, 0, 2));
        tick();
        lkup_vld = 1'b0; ic_hit = 1'b1;
        @(negedge clk);
        chk("flush_lookup_hit", outs(), ex('h30, 'h66, 0, 0, 0, 1, 1, 1, 2));
        tick();
        quiet();

        // reset in the middle of a fill wait
        lkup_vld = 1'b1; lkup_idx = 10'h40; lkup_tag = 18'h77;
        tick();
        lkup_vld = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_miss_before", outs(), ex('h40, 'h77, 0, 0, 1, 0, 0, 1, 3));
        reset = 1'b1;
        tick();
        reset = 1'b0; fill_ack = 1'b1;
        @(negedge clk);
        chk("rst_miss_after", outs(), ex(0, 0, 0, 1, 0, 0, 0, 1, 0));
        tick();
        fill_ack = 1'b0;
        for (int i = 1; i < 1024; i++) begin
            @(negedge clk);
            chk($sformatf("rst_walk%0d", i), outs(), ex(i, 0, 0, 1, 0, 0, 0, 1, 0));
            tick();
        end
        @(negedge clk);
        chk("rst_walk_end", 64'(busy), 64'd0);
        tick();

        // saturation and reset mid-flush on the narrow instance
        s_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("s_walk%0d", i), 64'({s_addr, s_we, s_busy}), 64'({2'(i), 2'b11}));
            tick();
        end
        for (int k = 1; k <= 4; k++) begin
            s_lkup_vld = 1'b1; s_lkup_idx = 2'(k); s_lkup_tag = 4'(k + 8);
            tick();
            s_lkup_vld = 1'b0; s_ic_hit = 1'b0;
            tick();
            s_fill_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("s_fill%0d", k), 64'(s_fill_req), 64'd1);
            tick();
            s_fill_ack = 1'b0;
            @(negedge clk);
            chk($sformatf("s_write%0d", k),
                64'({s_we, s_vld, s_addr, s_in, s_miss}),
                64'({2'b11, 2'(k), 4'(k + 8), 2'((k > 3) ? 3 : k)}));
            tick();
        end
        s_flush_req = 1'b1;
        tick();
        s_flush_req = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("s_flush_walk1", 64'({s_addr, s_we}), 64'({2'd1, 1'b1}));
        s_reset = 1'b1;
        tick();
        s_reset = 1'b0;
        @(negedge clk);
        chk("s_rst_flush", 64'({s_addr, s_we, s_vld, s_miss}), 64'({2'd0, 1'b1, 1'b0, 2'd0}));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
